// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, ALU control encodings and the
// decode control bundle carried through the pipeline registers.
package rv32i_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   localparam logic [1:0] ULA_ADD   = 2'b00;
   localparam logic [1:0] ULA_SUB   = 2'b01;
   localparam logic [1:0] ULA_FUNCT = 2'b10;
   localparam logic [1:0] ULA_PASS  = 2'b11;

   localparam logic [1:0] SRC1_RS1  = 2'b00;
   localparam logic [1:0] SRC1_PC   = 2'b01;
   localparam logic [1:0] SRC1_ZERO = 2'b10;

   localparam logic [1:0] SRC2_RS2  = 2'b00;
   localparam logic [1:0] SRC2_IMM  = 2'b01;
   localparam logic [1:0] SRC2_FOUR = 2'b10;

   typedef struct packed {
      logic       mem_rd;
      logic       mem_wr;
      logic       reg_wr;
      logic       mux_reg_wr;
      logic [1:0] ula_op;
      logic [1:0] alu_src1;
      logic [1:0] alu_src2;
      logic       jump;
      logic       branch;
      logic       jalr;
   } ctrl_t;

   // All-zero bundle: no register/memory write and no control transfer.
   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: decodes which source registers the ID
// instruction reads and compares them against a load sitting in EX.
module load_use_detect
   import rv32i_pkg::*;
(
   input  logic [6:0] id_opcode,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       ex_valid,
   input  logic       ex_mem_rd,
   input  logic [4:0] ex_rd,
   input  logic       flush_in,
   input  logic       hold_in,
   output logic       stall
);

   logic rs1_used;
   logic rs2_used;
   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      case (id_opcode)
         OP_R, OP_S, OP_B: begin
            rs1_used = 1'b1;
            rs2_used = 1'b1;
         end
         OP_I, OP_LOAD, OP_JALR: begin
            rs1_used = 1'b1;
         end
         default: begin
            rs1_used = 1'b0;
            rs2_used = 1'b0;
         end
      endcase
   end

   assign rs1_hit = rs1_used & (id_rs1 == ex_rd);
   assign rs2_hit = rs2_used & (id_rs2 == ex_rd);

   // x0 is never a real producer, so a load to x0 cannot create a hazard.
   assign stall = ex_valid & ex_mem_rd & (ex_rd != 5'd0)
                & (rs1_hit | rs2_hit) & ~flush_in & ~hold_in;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush,
// downstream hold and a saturating bubble counter.
module id_ex_stage_reg
   import rv32i_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       id_opcode,
   input  logic             id_mem_rd,
   input  logic             id_mem_wr,
   input  logic             id_reg_wr,
   input  logic             id_mux_reg_wr,
   input  logic [1:0]       id_ula_op,
   input  logic [1:0]       id_alu_src1,
   input  logic [1:0]       id_alu_src2,
   input  logic             id_jump,
   input  logic             id_branch,
   input  logic             id_jalr,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_rs1_val,
   input  logic [XLEN-1:0]  id_rs2_val,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic [2:0]       id_funct3,
   input  logic             id_funct7b5,
   input  logic             hold_in,
   input  logic             flush_in,
   output logic             ex_mem_rd,
   output logic             ex_mem_wr,
   output logic             ex_reg_wr,
   output logic             ex_mux_reg_wr,
   output logic [1:0]       ex_ula_op,
   output logic [1:0]       ex_alu_src1,
   output logic [1:0]       ex_alu_src2,
   output logic             ex_jump,
   output logic             ex_branch,
   output logic             ex_jalr,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_rs1_val,
   output logic [XLEN-1:0]  ex_rs2_val,
   output logic [XLEN-1:0]  ex_imm,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic [2:0]       ex_funct3,
   output logic             ex_funct7b5,
   output logic             ex_valid,
   output logic             load_use_stall,
   output logic [CNT_W-1:0] bubble_cnt
);

   ctrl_t             id_ctrl;
   ctrl_t             ctrl_q, ctrl_d;
   logic              valid_q, valid_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   rs1_val_q, rs1_val_d;
   logic [XLEN-1:0]   rs2_val_q, rs2_val_d;
   logic [XLEN-1:0]   imm_q, imm_d;
   logic [4:0]        rs1_q, rs1_d;
   logic [4:0]        rs2_q, rs2_d;
   logic [4:0]        rd_q, rd_d;
   logic [2:0]        funct3_q, funct3_d;
   logic              funct7b5_q, funct7b5_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              stall;

   assign id_ctrl = '{
      mem_rd:     id_mem_rd,
      mem_wr:     id_mem_wr,
      reg_wr:     id_reg_wr,
      mux_reg_wr: id_mux_reg_wr,
      ula_op:     id_ula_op,
      alu_src1:   id_alu_src1,
      alu_src2:   id_alu_src2,
      jump:       id_jump,
      branch:     id_branch,
      jalr:       id_jalr
   };

   load_use_detect u_lud (
      .id_opcode (id_opcode),
      .id_rs1    (id_rs1),
      .id_rs2    (id_rs2),
      .ex_valid  (valid_q),
      .ex_mem_rd (ctrl_q.mem_rd),
      .ex_rd     (rd_q),
      .flush_in  (flush_in),
      .hold_in   (hold_in),
      .stall     (stall)
   );

   always_comb begin
      ctrl_d     = ctrl_q;
      valid_d    = valid_q;
      pc_d       = pc_q;
      rs1_val_d  = rs1_val_q;
      rs2_val_d  = rs2_val_q;
      imm_d      = imm_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rd_d       = rd_q;
      funct3_d   = funct3_q;
      funct7b5_d = funct7b5_q;
      cnt_d      = cnt_q;
      if (!hold_in) begin
         // Datapath is don't-care under a bubble, so always load it.
         pc_d       = id_pc;
         rs1_val_d  = id_rs1_val;
         rs2_val_d  = id_rs2_val;
         imm_d      = id_imm;
         rs1_d      = id_rs1;
         rs2_d      = id_rs2;
         rd_d       = id_rd;
         funct3_d   = id_funct3;
         funct7b5_d = id_funct7b5;
         if (flush_in) begin
            ctrl_d  = CTRL_NOP;
            valid_d = 1'b0;
         end else if (stall) begin
            ctrl_d  = CTRL_NOP;
            valid_d = 1'b0;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
         end else begin
            ctrl_d  = id_ctrl;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q     <= CTRL_NOP;
         valid_q    <= 1'b0;
         pc_q       <= '0;
         rs1_val_q  <= '0;
         rs2_val_q  <= '0;
         imm_q      <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         funct3_q   <= '0;
         funct7b5_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         rs1_val_q  <= rs1_val_d;
         rs2_val_q  <= rs2_val_d;
         imm_q      <= imm_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         funct3_q   <= funct3_d;
         funct7b5_q <= funct7b5_d;
         cnt_q      <= cnt_d;
      end
   end

   assign ex_mem_rd      = ctrl_q.mem_rd;
   assign ex_mem_wr      = ctrl_q.mem_wr;
   assign ex_reg_wr      = ctrl_q.reg_wr;
   assign ex_mux_reg_wr  = ctrl_q.mux_reg_wr;
   assign ex_ula_op      = ctrl_q.ula_op;
   assign ex_alu_src1    = ctrl_q.alu_src1;
   assign ex_alu_src2    = ctrl_q.alu_src2;
   assign ex_jump        = ctrl_q.jump;
   assign ex_branch      = ctrl_q.branch;
   assign ex_jalr        = ctrl_q.jalr;
   assign ex_pc          = pc_q;
   assign ex_rs1_val     = rs1_val_q;
   assign ex_rs2_val     = rs2_val_q;
   assign ex_imm         = imm_q;
   assign ex_rs1         = rs1_q;
   assign ex_rs2         = rs2_q;
   assign ex_rd          = rd_q;
   assign ex_funct3      = funct3_q;
   assign ex_funct7b5    = funct7b5_q;
   assign ex_valid       = valid_q;
   assign load_use_stall = stall;
   assign bubble_cnt     = cnt_q;

endmodule
